// File: rtl/fetch_queue_pkg.sv
// Shared widths and entry layout for the fetch stage and its queue.
// An entry packs the instruction in [31:0] and its PC in [63:32].
package fetch_queue_pkg;
  localparam int          XLEN        = 32;
  localparam int          ENTRY_W     = 2 * XLEN;
  localparam logic [31:0] PC_STEP_DEF = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  function automatic entry_t pack_entry(input logic [XLEN-1:0] instr,
                                        input logic [XLEN-1:0] pc);
    entry_t e;
    e.pc    = pc;
    e.instr = instr;
    return e;
  endfunction
endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake: head entry offered with valid, taken with ready.
interface fetch_queue_if;
  import fetch_queue_pkg::*;
  logic            valid_po;
  logic [XLEN-1:0] instr_po;
  logic [XLEN-1:0] pc_po;
  logic            ready_pi;

  modport master (output valid_po, output instr_po, output pc_po, input ready_pi);
  modport slave  (input valid_po, input instr_po, input pc_po, output ready_pi);
endinterface

// File: rtl/fetch_fifo.sv
// DEPTH x 64 circular buffer with flush; storage clears on reset so the
// stale head reads as zero until the first write.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  entry_t           wdata,
  output entry_t           rdata,
  output logic [CNT_W-1:0] count
);
  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // storage is left alone; only the bookkeeping resets
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC, captures insMem data into a small
// queue and hands entries to decode; redirects flush, halt stops fetching.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter  int          DEPTH    = 4,
  parameter  logic [31:0] PC_RESET = 32'h0,
  parameter  logic [31:0] PC_STEP  = PC_STEP_DEF,
  localparam int          CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk_pi,
  input  logic             reset_pi,
  input  logic             halt_pi,
  input  logic             isTakenBranch_pi,
  input  logic [XLEN-1:0]  targetPC_pi,
  output logic [XLEN-1:0]  fetchPC_po,
  input  logic [XLEN-1:0]  instruction_pi,
  fetch_queue_if.master    dec,
  output logic [CNT_W-1:0] count_po
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic             halted_q, halted_d;
  logic             valid, pop, fetch;
  logic [CNT_W-1:0] count;
  entry_t           head;

  always_comb begin
    valid      = (count != '0) && !isTakenBranch_pi;
    pop        = valid && dec.ready_pi;
    // a full queue can still take a new entry when the head leaves this cycle
    fetch      = !halted_q && !halt_pi && !isTakenBranch_pi && ((count < FULL) || pop);
    halted_d   = halted_q || halt_pi;
    fetch_pc_d = fetch_pc_q;
    if (isTakenBranch_pi) fetch_pc_d = targetPC_pi;
    else if (fetch)       fetch_pc_d = fetch_pc_q + PC_STEP;
  end

  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      fetch_pc_q <= PC_RESET;
      halted_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      halted_q   <= halted_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk_pi),
    .rst   (reset_pi),
    .flush (isTakenBranch_pi),
    .push  (fetch),
    .pop   (pop),
    .wdata (pack_entry(instruction_pi, fetch_pc_q)),
    .rdata (head),
    .count (count)
  );

  assign fetchPC_po   = fetch_pc_q;
  assign count_po     = count;
  assign dec.valid_po = valid;
  assign dec.instr_po = head.instr;
  assign dec.pc_po    = head.pc;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: expected PCs are queued as each scenario
// is set up and checked against the head whenever decode takes an entry.
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        reset, halt, br;
  logic [31:0] target, fetch_pc, instr_in;
  logic [2:0]  count;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  fetch_queue_if dq ();

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign instr_in = mem_fn(fetch_pc);

  fetch_queue #(.DEPTH(4), .PC_RESET(32'h0), .PC_STEP(32'd4)) dut (
    .clk_pi           (clk),
    .reset_pi         (reset),
    .halt_pi          (halt),
    .isTakenBranch_pi (br),
    .targetPC_pi      (target),
    .fetchPC_po       (fetch_pc),
    .instruction_pi   (instr_in),
    .dec              (dq),
    .count_po         (count)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // if decode takes the head this cycle, it must be the next expected entry
  task automatic observe();
    logic [31:0] e;
    #1;
    if (dq.valid_po && dq.ready_pi) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL sb_unexpected_pop observed_pc=%h expected=none", dq.pc_po);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_pc", dq.pc_po, e);
        chk("sb_instr", dq.instr_po, mem_fn(e));
      end
    end
  endtask

  initial begin
    reset = 1'b1; halt = 1'b0; br = 1'b0; target = '0; dq.ready_pi = 1'b0;
    tick(); tick();
    chk("rst_fetch_pc", fetch_pc, 32'h0);
    chk("rst_valid", 32'(dq.valid_po), 32'd0);
    chk("rst_instr", dq.instr_po, 32'h0);
    chk("rst_pc", dq.pc_po, 32'h0);
    chk("rst_count", 32'(count), 32'd0);

    // streaming with decode always ready
    reset = 1'b0; dq.ready_pi = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("stream_count", 32'(count), 32'd1);
      chk("stream_valid", 32'(dq.valid_po), 32'd1);
      observe();
    end
    chk("stream_sb_empty", 32'(exp_q.size()), 32'd0);

    // fill to full with decode stalled
    reset = 1'b1; dq.ready_pi = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("fill_count", 32'(count), 32'(i));
    end
    chk("full_fetch_pc", fetch_pc, 32'd16);
    tick();
    chk("full_hold_count", 32'(count), 32'd4);
    chk("full_hold_pc", fetch_pc, 32'd16);
    exp_q.push_back(32'd0);
    dq.ready_pi = 1'b1;
    observe();
    tick();
    chk("full_pop_count", 32'(count), 32'd4);
    chk("full_pop_fetch_pc", fetch_pc, 32'd20);
    chk("full_pop_head", dq.pc_po, 32'd4);
    chk("full_pop_sb_empty", 32'(exp_q.size()), 32'd0);

    // redirect from a full queue
    dq.ready_pi = 1'b0; br = 1'b1; target = 32'h100;
    #1 chk("redir_valid_comb", 32'(dq.valid_po), 32'd0);
    tick();
    br = 1'b0;
    chk("redir_count", 32'(count), 32'd0);
    chk("redir_valid", 32'(dq.valid_po), 32'd0);
    chk("redir_fetch_pc", fetch_pc, 32'h100);
    tick();
    chk("redir_head_pc", dq.pc_po, 32'h100);
    chk("redir_head_instr", dq.instr_po, mem_fn(32'h100));
    chk("redir_head_count", 32'(count), 32'd1);

    // halt pulse with two entries queued
    tick();
    chk("halt_pre_count", 32'(count), 32'd2);
    chk("halt_pre_pc", fetch_pc, 32'h108);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    halt = 1'b1; dq.ready_pi = 1'b1;
    observe();
    tick();
    halt = 1'b0;
    chk("halt_count1", 32'(count), 32'd1);
    chk("halt_fetch_pc1", fetch_pc, 32'h108);
    observe();
    tick();
    chk("halt_count0", 32'(count), 32'd0);
    chk("halt_sb_empty", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("halt_valid_low", 32'(dq.valid_po), 32'd0);
      chk("halt_pc_frozen", fetch_pc, 32'h108);
      tick();
    end

    // redirect while halted: PC loads, nothing is fetched
    br = 1'b1; target = 32'hFFFF_FFF8;
    tick();
    br = 1'b0;
    chk("halt_redir_pc", fetch_pc, 32'hFFFF_FFF8);
    chk("halt_redir_count", 32'(count), 32'd0);
    tick();
    chk("halt_redir_nofetch", 32'(count), 32'd0);
    chk("halt_redir_pc_hold", fetch_pc, 32'hFFFF_FFF8);

    // PC wrap after reset clears halt
    reset = 1'b1; dq.ready_pi = 1'b0;
    tick();
    reset = 1'b0; br = 1'b1; target = 32'hFFFF_FFF8;
    tick();
    br = 1'b0;
    chk("wrap_target", fetch_pc, 32'hFFFF_FFF8);
    tick(); tick(); tick();
    chk("wrap_count", 32'(count), 32'd3);
    chk("wrap_fetch_pc", fetch_pc, 32'h4);
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    dq.ready_pi = 1'b1;
    for (int i = 0; i < 3; i++) begin
      observe();
      tick();
      chk("wrap_drain_count", 32'(count), 32'd3);
    end
    chk("wrap_sb_empty", 32'(exp_q.size()), 32'd0);

    // reset beats a pending redirect
    dq.ready_pi = 1'b0; reset = 1'b1; br = 1'b1; target = 32'h200;
    tick();
    reset = 1'b0; br = 1'b0;
    chk("rst_mid_count", 32'(count), 32'd0);
    chk("rst_mid_pc", fetch_pc, 32'h0);
    chk("rst_mid_valid", 32'(dq.valid_po), 32'd0);
    chk("rst_mid_head", dq.pc_po, 32'h0);
    tick();
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_head", dq.pc_po, 32'h0);
    chk("post_rst_instr", dq.instr_po, mem_fn(32'h0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
